// File: rtl/dram_bist_pkg.sv
// rtl/dram_bist_pkg.sv - state encoding and March C- element descriptors
package dram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ONLY,
        S_RD,
        S_WAIT,
        S_CHK,
        S_DONE
    } state_t;

    localparam int NUM_ELEMENTS = 6;
    localparam logic [2:0] LAST_ELEMENT = 3'(NUM_ELEMENTS - 1);

    // Bit i of each table describes march element Mi.
    localparam logic [NUM_ELEMENTS-1:0] ELEM_DIR_DOWN  = 6'b111000;
    localparam logic [NUM_ELEMENTS-1:0] ELEM_HAS_READ  = 6'b111110;
    localparam logic [NUM_ELEMENTS-1:0] ELEM_EXP_INV   = 6'b010100;
    localparam logic [NUM_ELEMENTS-1:0] ELEM_HAS_WRITE = 6'b011111;
    localparam logic [NUM_ELEMENTS-1:0] ELEM_WR_INV    = 6'b001010;

endpackage

// File: rtl/dram_bist_addr_gen.sv
// rtl/dram_bist_addr_gen.sv - loadable up/down address counter for the march sweep
module dram_bist_addr_gen #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_dir,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_dir;

    // Loading picks the sweep's start address; the direction is latched for the whole element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_dir  <= 1'b0;
        end else if (i_load) begin
            r_addr <= i_dir ? '1 : '0;
            r_dir  <= i_dir;
        end else if (i_advance) begin
            r_addr <= r_dir ? r_addr - ADDR_WIDTH'(1) : r_addr + ADDR_WIDTH'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = r_dir ? (r_addr == '0) : (r_addr == '1);

endmodule

// File: rtl/dram_march_bist.sv
// rtl/dram_march_bist.sv - March C- BIST initiator for the dram single-port array
module dram_march_bist
    import dram_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] PATTERN      = 8'h55
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [2:0]            fail_element,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam logic [1:0] WAIT_END = 2'(READ_LATENCY >= 2 ? READ_LATENCY - 2 : 0);

    state_t                r_state;
    logic [2:0]            r_elem;
    logic [1:0]            r_wait;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_data;
    logic [2:0]            r_fail_element;

    logic [2:0]            w_nxt_elem;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_last;
    logic                  w_load;
    logic                  w_load_dir;
    logic                  w_advance;
    logic                  w_mismatch;
    logic                  w_chk_ok;
    logic [DATA_WIDTH-1:0] w_exp;
    logic [DATA_WIDTH-1:0] w_wr_val;

    assign w_nxt_elem = r_elem + 3'd1;
    assign w_exp      = ELEM_EXP_INV[r_elem] ? ~PATTERN : PATTERN;
    assign w_wr_val   = ELEM_WR_INV[r_elem]  ? ~PATTERN : PATTERN;
    assign w_mismatch = (r_state == S_CHK) && ELEM_HAS_READ[r_elem] && (mem_data_out != w_exp);
    assign w_chk_ok   = (r_state == S_CHK) && !w_mismatch;

    // Terminal address hands straight over to the next element's start address.
    assign w_load     = ((r_state == S_IDLE) && start)
                     || ((r_state == S_WR_ONLY) && w_last)
                     || (w_chk_ok && w_last && (r_elem != LAST_ELEMENT));
    assign w_load_dir = (r_state == S_IDLE) ? ELEM_DIR_DOWN[0] : ELEM_DIR_DOWN[w_nxt_elem];
    assign w_advance  = ((r_state == S_WR_ONLY) && !w_last) || (w_chk_ok && !w_last);

    dram_bist_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_dir    (w_load_dir),
        .i_advance(w_advance),
        .o_addr   (w_addr),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_elem         <= '0;
            r_wait         <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_fail_addr    <= '0;
            r_fail_data    <= '0;
            r_fail_element <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state        <= S_WR_ONLY;
                        r_elem         <= '0;
                        r_busy         <= 1'b1;
                        r_pass         <= 1'b0;
                        r_fail_addr    <= '0;
                        r_fail_data    <= '0;
                        r_fail_element <= '0;
                    end
                end
                S_WR_ONLY: begin
                    if (w_last) begin
                        r_elem  <= w_nxt_elem;
                        r_state <= ELEM_HAS_READ[w_nxt_elem] ? S_RD : S_WR_ONLY;
                    end
                end
                S_RD: begin
                    r_wait  <= '0;
                    r_state <= (READ_LATENCY == 1) ? S_CHK : S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == WAIT_END) begin
                        r_state <= S_CHK;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                S_CHK: begin
                    if (w_mismatch) begin
                        r_fail_addr    <= w_addr;
                        r_fail_data    <= mem_data_out;
                        r_fail_element <= r_elem;
                        r_pass         <= 1'b0;
                        r_busy         <= 1'b0;
                        r_done         <= 1'b1;
                        r_state        <= S_DONE;
                    end else if (w_last && (r_elem == LAST_ELEMENT)) begin
                        r_pass  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_last) begin
                        r_elem  <= w_nxt_elem;
                        r_state <= ELEM_HAS_READ[w_nxt_elem] ? S_RD : S_WR_ONLY;
                    end else begin
                        r_state <= S_RD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign fail_addr    = r_fail_addr;
    assign fail_data    = r_fail_data;
    assign fail_element = r_fail_element;

    // The check-cycle write is gated by the compare so a failing location is left untouched.
    assign mem_we      = (r_state == S_WR_ONLY)
                      || (w_chk_ok && ELEM_HAS_WRITE[r_elem]);
    assign mem_address = r_busy ? w_addr : '0;
    assign mem_data_in = r_busy ? w_wr_val : '0;

endmodule
